// File: rtl/csa_pkg.sv
// Shared definitions for the nibble-serial adder and its 4-bit carry-select
// adder stage: nibble width and FSM state encodings (also used by the bench).
package csa_pkg;

  // Width of one adder pass; operands are processed one nibble per clock.
  localparam int NIB_W = 4;

  // Sequencer states; encodings are fixed so the bench can compare them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a counter indexing n nibbles, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/carry_select_adder.sv
// 4-bit carry-select adder: two ripple chains, one assuming carry-in 0 and
// one assuming carry-in 1, with the real carry-in selecting the result.
module carry_select_adder
  import csa_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             carry
);

  logic [NIB_W:0]   c0_chain;
  logic [NIB_W:0]   c1_chain;
  logic [NIB_W-1:0] s0_bits;
  logic [NIB_W-1:0] s1_bits;

  assign c0_chain[0] = 1'b0;
  assign c1_chain[0] = 1'b1;

  // Both speculative ripple chains are built bit by bit.
  generate
    for (genvar gi = 0; gi < NIB_W; gi++) begin : g_ripple
      assign s0_bits[gi]    = a[gi] ^ b[gi] ^ c0_chain[gi];
      assign c0_chain[gi+1] = (a[gi] & b[gi]) | (a[gi] & c0_chain[gi]) |
                              (b[gi] & c0_chain[gi]);
      assign s1_bits[gi]    = a[gi] ^ b[gi] ^ c1_chain[gi];
      assign c1_chain[gi+1] = (a[gi] & b[gi]) | (a[gi] & c1_chain[gi]) |
                              (b[gi] & c1_chain[gi]);
    end
  endgenerate

  assign sum   = cin ? s1_bits : s0_bits;
  assign carry = cin ? c1_chain[NIB_W] : c0_chain[NIB_W];

endmodule

// File: rtl/csa_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder. Operands are accepted in IDLE, then added one
// nibble per clock (LSB first) through a single carry_select_adder, with the
// carry held in a register between nibbles. The result is presented in DONE
// until the consumer takes it.
// Optional feature: define CSA_OVF_FLAG_EN to add the signed-overflow port ovf.
module csa_nibble_serial_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(N);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_next;
  logic             cout_reg;
  logic             out_valid_reg;
`ifdef CSA_OVF_FLAG_EN
  logic             ovf_reg;
`endif

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] csa_sum;
  logic             csa_carry;
  logic             last_nib;
  logic             accept;

  assign in_ready = (state_reg == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign last_nib = (idx_reg == IDX_W'(N - 1));

  // Pick the operand nibbles addressed by the current index.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        a_nib = a_reg[i*NIB_W +: NIB_W];
        b_nib = b_reg[i*NIB_W +: NIB_W];
      end
    end
  end

  carry_select_adder u_csa (
    .a     (a_nib),
    .b     (b_nib),
    .cin   (carry_reg),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // Only the addressed nibble of the sum changes; the rest holds.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_sum_nib
      assign sum_next[gi*NIB_W +: NIB_W] = (idx_reg == IDX_W'(gi)) ?
                                           csa_sum : sum_reg[gi*NIB_W +: NIB_W];
    end
  endgenerate

  // Sequencer: accept operands, step through nibbles, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      idx_reg       <= '0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
`ifdef CSA_OVF_FLAG_EN
      ovf_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
            sum_reg   <= '0;
`ifdef CSA_OVF_FLAG_EN
            ovf_reg   <= 1'b0;
`endif
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= csa_carry;
          idx_reg   <= idx_reg + IDX_W'(1);
          if (last_nib) begin
            cout_reg      <= csa_carry;
            out_valid_reg <= 1'b1;
`ifdef CSA_OVF_FLAG_EN
            // Same-sign operands whose result sign differs overflowed.
            ovf_reg       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                             (csa_sum[NIB_W-1] != a_reg[WIDTH-1]);
`endif
            state_reg     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
`ifdef CSA_OVF_FLAG_EN
  assign ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_csa_nibble_serial_adder.sv
// Self-checking bench for csa_nibble_serial_adder at WIDTH=16 and WIDTH=4.
// Expected results are pushed to scoreboard queues on accept and popped when
// the result is presented. Define CSA_OVF_FLAG_EN to also check ovf.
module tb_csa_nibble_serial_adder;
  import csa_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, cin16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4;
  logic [3:0]  a4, b4, sum4;
`ifdef CSA_OVF_FLAG_EN
  logic        ovf16, ovf4;
`endif

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [15:0] sum;
  } exp16_t;

  exp16_t     sb16[$];
  logic [4:0] sb4[$];

  int checks = 0;
  int errors = 0;

  csa_nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .cin       (cin16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .sum       (sum16),
    .cout      (cout16)
`ifdef CSA_OVF_FLAG_EN
    ,
    .ovf       (ovf16)
`endif
  );

  csa_nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .cout      (cout4)
`ifdef CSA_OVF_FLAG_EN
    ,
    .ovf       (ovf4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=16 transaction; optional DONE stall and junk input pulses.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input int stall, input logic junk);
    exp16_t      e;
    exp16_t      got;
    logic [16:0] full;
    int          cyc;
    full   = 17'(a) + 17'(b) + 17'(c);
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (a[15] == b[15]) && (full[15] != a[15]);
    cyc = 0;
    while (!in_ready16 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready16_idle", 32'(in_ready16), 32'd1);
    a16 = a; b16 = b; cin16 = c; in_valid16 = 1'b1;
    out_ready16 = (stall == 0);
    sb16.push_back(e);
    @(negedge clk);
    in_valid16 = junk;
    if (junk) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom_range(0, 1));
    end
    cyc = 0;
    while (!out_valid16 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("latency16", 32'(cyc), 32'd4);
    for (int i = 0; i < stall; i++) begin
      in_valid16 = junk;
      a16 = 16'($urandom); b16 = 16'($urandom);
      @(negedge clk);
      check("hold_sum16", 32'(sum16), 32'(sb16[0].sum));
      check("hold_cout16", 32'(cout16), 32'(sb16[0].cout));
      check("hold_in_ready16", 32'(in_ready16), 32'd0);
      check("hold_out_valid16", 32'(out_valid16), 32'd1);
    end
    in_valid16 = 1'b0;
    out_ready16 = 1'b1;
    got = sb16.pop_front();
    check("sum16", 32'(sum16), 32'(got.sum));
    check("cout16", 32'(cout16), 32'(got.cout));
`ifdef CSA_OVF_FLAG_EN
    check("ovf16", 32'(ovf16), 32'(got.ovf));
`endif
    $display("txn16 a=%h b=%h cin=%b -> sum=%h cout=%b", a, b, c, sum16, cout16);
    @(negedge clk);
    check("release16", 32'(out_valid16), 32'd0);
  endtask

  // One WIDTH=4 transaction.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] e;
    logic [4:0] got;
    int         cyc;
    e = 5'(a) + 5'(b) + 5'(c);
    cyc = 0;
    while (!in_ready4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    a4 = a; b4 = b; cin4 = c; in_valid4 = 1'b1; out_ready4 = 1'b1;
    sb4.push_back(e);
    @(negedge clk);
    in_valid4 = 1'b0;
    cyc = 0;
    while (!out_valid4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("latency4", 32'(cyc), 32'd1);
    got = sb4.pop_front();
    check("sum_cout4", 32'({cout4, sum4}), 32'(got));
    $display("txn4 a=%h b=%h cin=%b -> sum=%h cout=%b", a, b, c, sum4, cout4);
    @(negedge clk);
    check("release4", 32'(out_valid4), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
    #1;
    check("rst_in_ready16", 32'(in_ready16), 32'd1);
    check("rst_out_valid16", 32'(out_valid16), 32'd0);
    check("rst_sum16", 32'(sum16), 32'd0);
    check("rst_cout16", 32'(cout16), 32'd0);
    check("rst_state16", 32'(dut16.state_reg), 32'(ST_IDLE));
    check("rst_in_ready4", 32'(in_ready4), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready16", 32'(in_ready16), 32'd1);

    // Directed cases
    run16(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run16(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
    run16(16'h1234, 16'h4321, 1'b1, 5, 1'b1);
    run16(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    run16(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0);
    run16(16'h8000, 16'h8000, 1'b0, 2, 1'b0);
    run16(16'h0000, 16'h0000, 1'b0, 0, 1'b1);
    run4(4'b1110, 4'b1110, 1'b1);
    run4(4'hF, 4'h0, 1'b1);

    // Asynchronous reset at idx=2 of RUN
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; in_valid16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_idx16", 32'(dut16.idx_reg), 32'd2);
    check("mid_partial16", 32'(sum16), 32'h0055);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid16", 32'(out_valid16), 32'd0);
    check("arst_sum16", 32'(sum16), 32'd0);
    check("arst_in_ready16", 32'(in_ready16), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run16(16'hA5A5, 16'h5A5B, 1'b0, 0, 1'b0);

    // Random vectors
    for (int i = 0; i < 1000; i++)
      run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0,
            1'($urandom_range(0, 1)));
    for (int i = 0; i < 1000; i++)
      run4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));

    check("sb16_empty", 32'(sb16.size()), 32'd0);
    check("sb4_empty", 32'(sb4.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
